// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result and an iterative
// shift-add multiplier. One operation per input transaction; the result
// sits in the output register until the consumer takes it.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for a request; single-cycle ops complete here
// S_MUL  | shift-add multiply running, one iteration per clock edge
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic             busy
);

  localparam logic [3:0] F_AND  = 4'b0000;
  localparam logic [3:0] F_OR   = 4'b0001;
  localparam logic [3:0] F_ADD  = 4'b0010;
  localparam logic [3:0] F_ANDN = 4'b0100;
  localparam logic [3:0] F_ORN  = 4'b0101;
  localparam logic [3:0] F_SUB  = 4'b0110;
  localparam logic [3:0] F_SLT  = 4'b0111;
  localparam logic [3:0] F_SLL  = 4'b1000;
  localparam logic [3:0] F_SRL  = 4'b1001;
  localparam logic [3:0] F_SRA  = 4'b1010;
  localparam logic [3:0] F_MUL  = 4'b1011;

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             accept;
  logic             drain;
  logic [SHW-1:0]   sh_amt;
  logic [WIDTH-1:0] sum_add;
  logic [WIDTH-1:0] sum_sub;
  logic             slt_bit;
  logic [WIDTH-1:0] res_y;
  logic             res_ovf;
  logic             res_illegal;
  logic [WIDTH-1:0] acc_step;
  logic             last_iter;

  // A new request may only enter when idle and the result slot is free
  // or being emptied on this same edge, so a result is never overwritten.
  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid_q && out_ready;

  assign sh_amt    = b[SHW-1:0];
  assign sum_add   = a + b;
  assign sum_sub   = a + ~b + WIDTH'(1);
  assign slt_bit   = $signed(a) < $signed(b);

  assign acc_step  = acc_q + (mb_q[0] ? ma_q : '0);
  assign last_iter = (cnt_q == LAST_ITER);

  // Single-cycle result for every non-multiply function code.
  always_comb begin
    res_y       = '0;
    res_ovf     = 1'b0;
    res_illegal = 1'b0;
    unique case (f)
      F_AND:  res_y = a & b;
      F_OR:   res_y = a | b;
      F_ADD: begin
        res_y   = sum_add;
        res_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
      end
      F_ANDN: res_y = a & ~b;
      F_ORN:  res_y = a | ~b;
      F_SUB: begin
        res_y   = sum_sub;
        res_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
      end
      F_SLT:  res_y = {{(WIDTH-1){1'b0}}, slt_bit};
      F_SLL:  res_y = a << sh_amt;
      F_SRL:  res_y = a >> sh_amt;
      F_SRA:  res_y = WIDTH'($signed(a) >>> sh_amt);
      // MUL never takes this path; it is routed to the iterative unit.
      F_MUL:  res_y = '0;
      default: res_illegal = 1'b1;
    endcase
  end

  // Next-state logic: request acceptance, multiply iterations, output slot.
  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    acc_d       = acc_q;

    if (drain) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (f == F_MUL) begin
            state_d = S_MUL;
            ma_d    = a;
            mb_d    = b;
            acc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end else begin
            y_d         = res_y;
            zero_d      = (res_y == '0);
            ovf_d       = res_ovf;
            illegal_d   = res_illegal;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        // Multiplicand walks left, multiplier walks right; each edge adds
        // the multiplicand when the current multiplier LSB is set.
        acc_d = acc_step;
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + SHW'(1);
        if (last_iter) begin
          state_d     = S_IDLE;
          y_d         = acc_step;
          zero_d      = (acc_step == '0);
          ovf_d       = 1'b0;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset abandons any multiply in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      y_q         <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      acc_q       <= acc_d;
    end
  end

  assign y         = y_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=32): directed corner cases, then
// randomized traffic with random backpressure against a reference model.
module tb_alu_pipe;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    f = 4'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  y;
  logic          zero;
  logic          ovf;
  logic          illegal;
  logic          busy;

  typedef struct packed {
    logic [31:0] y;
    logic        zero;
    logic        ovf;
    logic        illegal;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_ready = 1'b0;
  int   cyc = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .f(f), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .ovf(ovf), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] yv, input logic zv, input logic ov, input logic il);
    exp_t e;
    e.y = yv; e.zero = zv; e.ovf = ov; e.illegal = il;
    return e;
  endfunction

  // Reference model: signed results computed in 64-bit arithmetic.
  function automatic exp_t model(input logic [3:0] fc, input logic [31:0] av, input logic [31:0] bv);
    exp_t        e;
    longint      sa, sb, r;
    logic [63:0] p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    e = mk(32'h0, 1'b0, 1'b0, 1'b0);
    case (fc)
      4'd0:  e.y = av & bv;
      4'd1:  e.y = av | bv;
      4'd2: begin
        r = sa + sb; e.y = r[31:0];
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd4:  e.y = av & ~bv;
      4'd5:  e.y = av | ~bv;
      4'd6: begin
        r = sa - sb; e.y = r[31:0];
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd7:  e.y = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  e.y = av << bv[4:0];
      4'd9:  e.y = av >> bv[4:0];
      4'd10: begin r = sa >>> bv[4:0]; e.y = r[31:0]; end
      4'd11: begin p = {32'h0, av} * {32'h0, bv}; e.y = p[31:0]; end
      default: e.illegal = 1'b1;
    endcase
    e.zero = (e.y == 32'h0);
    return e;
  endfunction

  // Monitor: whenever a result is presented, it must match the oldest
  // expectation; it is retired only when the consumer takes it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q[0];
          chk("y", y, e.y);
          chk("zero", 32'(zero), 32'(e.zero));
          chk("ovf", 32'(ovf), 32'(e.ovf));
          chk("illegal", 32'(illegal), 32'(e.illegal));
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  // Present a request until accepted; expectation is pushed at acceptance.
  task automatic send(input logic [3:0] fc, input logic [31:0] av, input logic [31:0] bv,
                      input bit use_exp, input exp_t ex);
    exp_t e;
    e = use_exp ? ex : model(fc, av, bv);
    f = fc; a = av; b = bv; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        f = 4'($urandom); a = $urandom; b = $urandom;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        return;
      end
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
    chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_y"}, y, 32'h0);
    chk({tag, "_flags"}, {28'h0, zero, ovf, illegal, busy}, 32'h0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic [31:0] rand_opnd();
    logic [31:0] corners [5];
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int  c0;
    bit  seen;
    exp_t dummy;
    dummy = mk(32'h0, 1'b0, 1'b0, 1'b0);

    #12;
    chk_all_zero("reset");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Arithmetic corners and latency
    send(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    chk("add_latency", 32'(out_valid), 32'd1);
    send(4'b0110, 32'd5, 32'd5, 1'b1, mk(32'h0, 1'b1, 1'b0, 1'b0));
    send(4'b0111, 32'h8000_0000, 32'h1, 1'b1, mk(32'h1, 1'b0, 1'b0, 1'b0));
    send(4'b1010, 32'hF000_0000, 32'h24, 1'b1, mk(32'hFF00_0000, 1'b0, 1'b0, 1'b0));
    send(4'b1000, 32'h1, 32'd31, 1'b1, mk(32'h8000_0000, 1'b0, 1'b0, 1'b0));
    send(4'b1001, 32'h8000_0000, 32'd31, 1'b1, mk(32'h1, 1'b0, 1'b0, 1'b0));
    send(4'b0011, 32'h1234, 32'h5678, 1'b1, mk(32'h0, 1'b1, 1'b0, 1'b1));
    send(4'b1100, 32'hFFFF_FFFF, 32'h1, 1'b1, mk(32'h0, 1'b1, 1'b0, 1'b1));
    send(4'b0000, 32'hFF, 32'h0F, 1'b1, mk(32'h0F, 1'b0, 1'b0, 1'b0));

    // Throughput: four single-cycle ops on four consecutive edges
    c0 = cyc;
    for (int i = 0; i < 4; i++) send(4'b0001, rand_opnd(), rand_opnd(), 1'b0, dummy);
    chk("back_to_back_cycles", 32'(cyc - c0), 32'd4);

    // Multiply: busy for WIDTH edges, then the product
    send(4'b1011, 32'h0001_0003, 32'h0002_0005, 1'b1, mk(32'h000B_000F, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < W; i++) begin
      chk("mul_busy", {30'h0, busy, in_ready}, 32'd2);
      @(posedge clk); #1;
    end
    chk("mul_done", {30'h0, busy, out_valid}, 32'd1);
    @(posedge clk); #1;

    // Reset after ten multiply iterations: no result may appear
    send(4'b1011, 32'hFFFF, 32'hFFFF, 1'b0, dummy);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    sb_q.delete();
    #1 chk_all_zero("mul_abort");
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mul_abort_no_result", 32'(seen), 32'd0);
    chk("mul_abort_in_ready", 32'(in_ready), 32'd1);

    // Backpressure: first result held, second request waits, then both move
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'b0010, 32'd2, 32'd3, 1'b1, mk(32'd5, 1'b0, 1'b0, 1'b0));
    f = 4'b0110; a = 32'd9; b = 32'd2; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    chk("bp_hold_y", y, 32'd5);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    sb_q.push_back(mk(32'd7, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_loaded", {y[30:0], out_valid}, {31'd7, 1'b1});
    @(posedge clk); #1;

    // Reset mid-cycle with a pending result
    out_ready = 1'b0;
    send(4'b0010, 32'd1, 32'd1, 1'b1, mk(32'd2, 1'b0, 1'b0, 1'b0));
    #3 reset = 1'b1;
    sb_q.delete();
    #1 chk_all_zero("async_reset");
    @(negedge clk); reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Random traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] fr;
      logic [31:0] ar, br;
      fr = 4'($urandom);
      ar = rand_opnd();
      br = rand_opnd();
      send(fr, ar, br, 1'b0, dummy);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
